// File: rtl/vga_timing_controller_if.sv
// vga_timing_controller_if: drawer-side and DAC-side signals of the VGA raster timing controller
// master = timing controller (drives coordinates, strobes, syncs and colour to the DAC)
// slave  = drawer/DAC side (drives R_i/G_i/B_i, observes everything else)
interface vga_timing_controller_if;
  logic [7:0] R_i;
  logic [7:0] G_i;
  logic [7:0] B_i;
  logic [9:0] x_o;
  logic [9:0] y_o;
  logic       pixel_tick_o;
  logic       frame_start_o;
  logic       hsync_o;
  logic       vsync_o;
  logic       blank_n_o;
  logic       sync_n_o;
  logic       vga_clk_o;
  logic [7:0] R_o;
  logic [7:0] G_o;
  logic [7:0] B_o;
  modport master (
    input  R_i, G_i, B_i,
    output x_o, y_o, pixel_tick_o, frame_start_o, hsync_o, vsync_o,
           blank_n_o, sync_n_o, vga_clk_o, R_o, G_o, B_o
  );
  modport slave (
    output R_i, G_i, B_i,
    input  x_o, y_o, pixel_tick_o, frame_start_o, hsync_o, vsync_o,
           blank_n_o, sync_n_o, vga_clk_o, R_o, G_o, B_o
  );
endinterface

// File: rtl/vga_timing_controller.sv
// vga_timing_controller: VGA raster timing generator with registered sync/blank/colour toward the DAC
// clk/rst: system clock, synchronous active-high reset
// bus (master): R_i/G_i/B_i drawer colour in; x_o/y_o raw counters, pixel_tick_o, frame_start_o,
//               hsync_o/vsync_o (active low), blank_n_o, sync_n_o (tied 0), vga_clk_o, R_o/G_o/B_o out
module vga_timing_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input logic                    clk,
  input logic                    rst,
  vga_timing_controller_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);
  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_hs;
  logic          r_vs;
  logic          r_bn;
  logic [7:0]    r_r;
  logic [7:0]    r_g;
  logic [7:0]    r_b;
  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_vis;
  logic          w_hs_on;
  logic          w_vs_on;
  assign w_tick   = r_div == DW'(CLK_DIV - 1);
  assign w_h_last = r_h == 10'(H_TOTAL - 1);
  assign w_v_last = r_v == 10'(V_TOTAL - 1);
  assign w_vis    = (r_h < 10'(H_VISIBLE)) && (r_v < 10'(V_VISIBLE));
  assign w_hs_on  = (r_h >= 10'(H_VISIBLE + H_FRONT)) && (r_h < 10'(H_VISIBLE + H_FRONT + H_SYNC));
  assign w_vs_on  = (r_v >= 10'(V_VISIBLE + V_FRONT)) && (r_v < 10'(V_VISIBLE + V_FRONT + V_SYNC));
  // Sync/blank/colour are computed from the pre-increment counters, so they lag x_o/y_o by one pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_bn  <= 1'b0;
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        r_h  <= w_h_last ? '0 : r_h + 10'd1;
        r_v  <= w_h_last ? (w_v_last ? '0 : r_v + 10'd1) : r_v;
        r_hs <= !w_hs_on;
        r_vs <= !w_vs_on;
        r_bn <= w_vis;
        r_r  <= w_vis ? bus.R_i : '0;
        r_g  <= w_vis ? bus.G_i : '0;
        r_b  <= w_vis ? bus.B_i : '0;
      end
    end
  end
  // Strobes are gated by rst so they stay low throughout a reset cycle, even mid-frame.
  assign bus.pixel_tick_o  = w_tick && !rst;
  assign bus.frame_start_o = w_tick && !rst && (r_h == '0) && (r_v == '0);
  assign bus.vga_clk_o     = r_div >= DW'(CLK_DIV / 2);
  assign bus.x_o           = r_h;
  assign bus.y_o           = r_v;
  assign bus.hsync_o       = r_hs;
  assign bus.vsync_o       = r_vs;
  assign bus.blank_n_o     = r_bn;
  assign bus.sync_n_o      = 1'b0;
  assign bus.R_o           = r_r;
  assign bus.G_o           = r_g;
  assign bus.B_o           = r_b;
endmodule

// File: tb/tb_vga_timing_controller.sv
// tb_vga_timing_controller: scoreboard bench for vga_timing_controller on a shrunken raster
module tb_vga_timing_controller;
  localparam int HV = 10, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int CD = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam logic [26:0] RST_OUT = {1'b1, 1'b1, 1'b0, 24'h0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_timing_controller_if bus();
  vga_timing_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int m_div = 0, m_h = 0, m_v = 0;
  int mode = 0;
  int cyc_cnt = 0, last_fs = 0, vis_cnt = 0, hs_run = 0;
  bit fvalid = 0;
  logic [26:0] cur = RST_OUT;
  logic [26:0] q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, m_h, m_v);
    end
  endtask
  function automatic logic [26:0] exp_of(input int h, input int v, input logic [7:0] r,
                                         input logic [7:0] g, input logic [7:0] b);
    logic hs, vs, vis;
    hs  = !(h >= HV + HF && h < HV + HF + HS);
    vs  = !(v >= VV + VF && v < VV + VF + VS);
    vis = h < HV && v < VV;
    return {hs, vs, vis, vis ? r : 8'h0, vis ? g : 8'h0, vis ? b : 8'h0};
  endfunction
  task automatic cyc(input logic r);
    logic tick;
    @(negedge clk);
    rst = r;
    if (mode == 0) {bus.R_i, bus.G_i, bus.B_i} = 24'hFFFFFF;
    else if (mode == 1) {bus.R_i, bus.G_i, bus.B_i} = {bus.x_o[7:0], bus.y_o[7:0], 8'h5A};
    else {bus.R_i, bus.G_i, bus.B_i} = 24'($urandom);
    #1;
    tick = (m_div == CD - 1) && !r;
    chk("tick", bus.pixel_tick_o, tick);
    chk("frame_start", bus.frame_start_o, tick && m_h == 0 && m_v == 0);
    chk("x", bus.x_o, m_h);
    chk("y", bus.y_o, m_v);
    if (tick) q.push_back(exp_of(m_h, m_v, bus.R_i, bus.G_i, bus.B_i));
    if (tick && bus.frame_start_o) begin
      if (fvalid) begin
        chk("frame_period", cyc_cnt - last_fs, HT * VT * CD);
        chk("visible_count", vis_cnt, HV * VV);
      end
      fvalid = 1;
      last_fs = cyc_cnt;
      vis_cnt = 0;
    end
    @(posedge clk);
    cyc_cnt++;
    if (r) begin
      m_div = 0; m_h = 0; m_v = 0;
      q.delete();
      cur = RST_OUT;
      fvalid = 0; vis_cnt = 0; hs_run = 0;
    end else begin
      if (tick) begin
        if (q.size() == 0) chk("queue_empty", 1, 0);
        else cur = q.pop_front();
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else m_h++;
      end
      m_div = tick ? 0 : m_div + 1;
    end
    #1;
    chk("hsync", bus.hsync_o, cur[26]);
    chk("vsync", bus.vsync_o, cur[25]);
    chk("blank_n", bus.blank_n_o, cur[24]);
    chk("rgb", {bus.R_o, bus.G_o, bus.B_o}, cur[23:0]);
    chk("vga_clk", bus.vga_clk_o, m_div >= CD / 2);
    chk("sync_n", bus.sync_n_o, 0);
    if (tick && !r) begin
      if (bus.blank_n_o) vis_cnt++;
      if (!bus.hsync_o) hs_run++;
      else if (hs_run != 0) begin
        chk("hsync_len", hs_run, HS);
        hs_run = 0;
      end
    end
  endtask
  initial begin
    bit hit;
    {bus.R_i, bus.G_i, bus.B_i} = 24'h0;
    repeat (3) @(posedge clk);
    repeat (2) cyc(1);
    mode = 0;
    repeat (2 * HT * VT * CD + 20) cyc(0);
    mode = 1;
    repeat (2 * HT * VT * CD + 20) cyc(0);
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (m_h == 5 && m_v == 3) hit = 1;
      else cyc(0);
    end
    chk("mid_reset_reached", hit, 1);
    cyc(1);
    mode = 2;
    repeat (2 * HT * VT * CD + 20) cyc(0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
